spi_slave_stream: RTL

Parametrised SPI slave for streaming multi-word frames with a runtime-selectable mode. It sits between an external SPI master and an on-chip datapath. Transmit words arrive over a valid/ready handshake and are shifted out on `miso`; received words leave as single-cycle `rx_valid` pulses. One chip-select assertion may carry any number of back-to-back words.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_slave_stream_if.sv | 27 ++
 rtl/spi_edge_sync.sv | 79 +++++++
 rtl/spi_slave_stream.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and helpers for the SPI slave stream block.
// Holds the FSM state enum, mode bit positions and the edge-role decode.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XFER = 2'd2
    } state_e;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

    // Mode 0 and 3 sample on the rising sclk edge, modes 1 and 2 on falling.
    function automatic logic sample_on_rise(input logic [1:0] m);
        return ~(m[CPOL_BIT] ^ m[CPHA_BIT]);
    endfunction

endpackage

// File: rtl/spi_slave_stream_if.sv
// spi_slave_stream_if: word stream handshake between datapath and SPI slave.
// The datapath side uses the master modport, the slave block the slave one.
interface spi_slave_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid
    );
endinterface

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: pin registration and edge detect for sclk, csn and mosi.
// SPI_SLAVE_SYNC_EN adds two-flop synchronisers ahead of the edge register.
module spi_edge_sync (
    input  logic clk,
    input  logic arst,
    input  logic cpol,
    input  logic sclk,
    input  logic csn,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic csn_fall,
    output logic csn_rise,
    output logic mosi_s
);
    logic       sclk_in, csn_in, mosi_in;
    logic       sclk_s_q, csn_s_q, mosi_s_q;
    logic       sclk_prev_q, csn_prev_q;
    logic [1:0] fill_q;
    logic       armed_q;

`ifdef SPI_SLAVE_SYNC_EN
    localparam logic [1:0] FILL = 2'd3;
    logic [1:0] sclk_m_q, csn_m_q, mosi_m_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sclk_m_q <= '0;
            csn_m_q  <= '1;
            mosi_m_q <= '0;
        end else begin
            sclk_m_q <= {sclk_m_q[0], sclk};
            csn_m_q  <= {csn_m_q[0], csn};
            mosi_m_q <= {mosi_m_q[0], mosi};
        end
    end

    assign sclk_in = sclk_m_q[1];
    assign csn_in  = csn_m_q[1];
    assign mosi_in = mosi_m_q[1];
`else
    localparam logic [1:0] FILL = 2'd1;

    assign sclk_in = sclk;
    assign csn_in  = csn;
    assign mosi_in = mosi;
`endif

    // A csn low seen only through the reset preset must not start a frame.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sclk_s_q    <= 1'b0;
            csn_s_q     <= 1'b1;
            mosi_s_q    <= 1'b0;
            sclk_prev_q <= 1'b0;
            csn_prev_q  <= 1'b1;
            fill_q      <= '0;
            armed_q     <= 1'b0;
        end else begin
            sclk_s_q    <= sclk_in;
            csn_s_q     <= csn_in;
            mosi_s_q    <= mosi_in;
            csn_prev_q  <= csn_s_q;
            sclk_prev_q <= csn_fall ? cpol : sclk_s_q;
            if (fill_q != FILL) begin
                fill_q <= fill_q + 2'd1;
            end else if (csn_s_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign csn_fall  = armed_q & csn_prev_q & ~csn_s_q;
    assign csn_rise  = ~csn_prev_q & csn_s_q;
    assign sclk_rise = sclk_s_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s_q & sclk_prev_q;
    assign mosi_s    = mosi_s_q;

endmodule

// File: rtl/spi_slave_stream.sv
// spi_slave_stream: SPI slave streaming multi-word frames, runtime mode.
// Synchroniser depth is selected by SPI_SLAVE_SYNC_EN inside spi_edge_sync.
module spi_slave_stream
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic [1:0]           mode,
    input  logic                 sclk,
    input  logic                 csn,
    input  logic                 mosi,
    output logic                 miso,
    spi_slave_stream_if.slave    bus,
    output logic                 frame_active,
    output logic [CNT_WIDTH-1:0] word_cnt,
    output logic                 underrun,
    output logic                 frame_err
);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    logic sclk_rise, sclk_fall, csn_fall, csn_rise, mosi_s;

    spi_edge_sync u_sync (
        .clk       (clk),
        .arst      (arst),
        .cpol      (mode[CPOL_BIT]),
        .sclk      (sclk),
        .csn       (csn),
        .mosi      (mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .csn_fall  (csn_fall),
        .csn_rise  (csn_rise),
        .mosi_s    (mosi_s)
    );

    state_e                state_q;
    logic [1:0]            mode_q;
    logic [BW-1:0]         bit_cnt_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [DATA_WIDTH-1:0] rx_shreg_q, rx_shreg_d;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic [CNT_WIDTH-1:0]  word_cnt_q;
    logic                  rx_valid_q, underrun_q, frame_err_q;
    logic                  frame_active_q;
    logic                  sample_edge, shift_edge, last_bit, load_now;

    always_comb begin
        sample_edge = 1'b0;
        shift_edge  = 1'b0;
        if (state_q == XFER) begin
            if (sample_on_rise(mode_q)) begin
                sample_edge = sclk_rise;
                shift_edge  = sclk_fall;
            end else begin
                sample_edge = sclk_fall;
                shift_edge  = sclk_rise;
            end
        end
        last_bit = sample_edge && (bit_cnt_q == BW'(DATA_WIDTH - 1));
        // Shift edges with no bit yet sampled in the word are load edges.
        load_now = !csn_rise &&
                   ((state_q == LOAD && !mode_q[CPHA_BIT]) ||
                    (shift_edge && bit_cnt_q == '0));
        rx_shreg_d = MSB_FIRST ? {rx_shreg_q[DATA_WIDTH-2:0], mosi_s}
                               : {mosi_s, rx_shreg_q[DATA_WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q        <= IDLE;
            mode_q         <= '0;
            bit_cnt_q      <= '0;
            shreg_q        <= '0;
            rx_shreg_q     <= '0;
            rx_data_q      <= '0;
            word_cnt_q     <= '0;
            rx_valid_q     <= 1'b0;
            underrun_q     <= 1'b0;
            frame_err_q    <= 1'b0;
            frame_active_q <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;

            if (load_now) begin
                shreg_q    <= bus.tx_valid ? bus.tx_data : '0;
                underrun_q <= !bus.tx_valid;
            end else if (shift_edge) begin
                shreg_q <= MSB_FIRST ? {shreg_q[DATA_WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg_q[DATA_WIDTH-1:1]};
            end

            if (sample_edge) begin
                rx_shreg_q <= rx_shreg_d;
                if (last_bit) begin
                    bit_cnt_q  <= '0;
                    rx_data_q  <= rx_shreg_d;
                    rx_valid_q <= 1'b1;
                    if (word_cnt_q != '1) begin
                        word_cnt_q <= word_cnt_q + 1'b1;
                    end
                end else begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end

            unique case (state_q)
                IDLE: begin
                    if (csn_fall) begin
                        mode_q         <= mode;
                        bit_cnt_q      <= '0;
                        word_cnt_q     <= '0;
                        frame_active_q <= 1'b1;
                        state_q        <= LOAD;
                    end
                end
                LOAD: begin
                    if (csn_rise) begin
                        frame_active_q <= 1'b0;
                        state_q        <= IDLE;
                    end else begin
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (csn_rise) begin
                        // A word completing on this very cycle is not partial.
                        frame_err_q    <= (bit_cnt_q != '0) && !last_bit;
                        bit_cnt_q      <= '0;
                        frame_active_q <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign miso         = MSB_FIRST ? shreg_q[DATA_WIDTH-1] : shreg_q[0];
    assign bus.tx_ready = load_now;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign frame_active = frame_active_q;
    assign word_cnt     = word_cnt_q;
    assign underrun     = underrun_q;
    assign frame_err    = frame_err_q;

endmodule
